dmem_vec: RTL and testbench

Parametrised byte-storage data memory shared by the scalar core, the vector unit and the VGA scanout. It has three ports: a scalar read/write port, an N-lane vector port with a valid/ready request and response handshake, and a read-only display port. Storage is split into LANES banks, interleaved by address (bank = addr mod LANES). Lanes that hit the same bank in one request are serialised over several cycles by a small issue FSM. All reads are registered, with 1-cycle latency.

---
 rtl/dmem_vec.sv | 234 +++++++++++++++++++++++
 tb/tb_dmem_vec.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_vec.sv
// dmem_vec: byte data memory split into LANES address-interleaved banks
// (bank = addr mod LANES). It has a scalar read/write port, an N-lane vector
// port with request/response handshakes, and a read-only display port.
// Lanes that collide on a bank are serialised by the ISSUE state.
// Optional build: define DMEM_VEC_CONFLICT_CNT_EN to build the bank-conflict
// cycle counter on conflict_cycles; otherwise that output is tied to zero.
module dmem_vec #(
   parameter int DEPTH = 1024,
   parameter int LANES = 4,
   parameter int AW    = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     we,
   input  logic [AW-1:0]            a,
   input  logic [31:0]              wd,
   output logic [31:0]              rd,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_we,
   input  logic [LANES-1:0]         lane_en,
   input  logic [LANES-1:0][AW-1:0] va,
   input  logic [LANES-1:0][31:0]   wdv,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [LANES-1:0][31:0]   rdv,
   input  logic [AW-1:0]            avga,
   output logic [31:0]              rdvga,
   output logic                     oob_err,
   output logic [31:0]              conflict_cycles
);

   localparam int ROWS = DEPTH / LANES;
   localparam int BKW  = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t state, state_nxt;

   // Captured request
   logic                     req_we_q;
   logic [LANES-1:0][AW-1:0] va_q;
   logic [LANES-1:0][7:0]    wd_q;
   logic [LANES-1:0]         pending;

   // Per-lane grant for the current ISSUE cycle, and per-bank occupancy
   logic [LANES-1:0]         grant;
   logic [LANES-1:0]         bank_busy;
   logic                     lane_oob;

   // Per-bank write port and read taps
   logic [LANES-1:0]         bk_we;
   logic [LANES-1:0][RW-1:0] bk_wrow;
   logic [LANES-1:0][7:0]    bk_wdat;
   logic [LANES-1:0][RW-1:0] bk_rrow;
   logic [LANES-1:0][7:0]    sc_rd;
   logic [LANES-1:0][7:0]    vga_rd;
   logic [LANES-1:0][7:0]    lane_rd;

   logic [BKW-1:0]           sc_bank;
   logic [BKW-1:0]           vga_bank;
   logic                     unused_hi;

   function automatic logic in_range(input logic [AW-1:0] x);
      return x < AW'(DEPTH);
   endfunction

   function automatic logic [BKW-1:0] bank_of(input logic [AW-1:0] x);
      return BKW'(x % AW'(LANES));
   endfunction

   function automatic logic [RW-1:0] row_of(input logic [AW-1:0] x);
      return RW'(x / AW'(LANES));
   endfunction

   assign sc_bank  = bank_of(a);
   assign vga_bank = bank_of(avga);

   // Only the low byte of each write-data word is stored
   always_comb begin
      unused_hi = ^wd[31:8];
      for (int unsigned l = 0; l < LANES; l++) begin
         unused_hi = unused_hi ^ (^wdv[l][31:8]);
      end
   end

   // Per bank, grant the lowest pending lane; a scalar write owns its bank
   always_comb begin
      grant     = '0;
      bank_busy = '0;
      lane_oob  = 1'b0;
      if (state == ISSUE) begin
         if (we) bank_busy[sc_bank] = 1'b1;
         for (int unsigned l = 0; l < LANES; l++) begin
            if (pending[l] && !bank_busy[bank_of(va_q[l])]) begin
               grant[l]                      = 1'b1;
               bank_busy[bank_of(va_q[l])]   = 1'b1;
               if (!in_range(va_q[l])) lane_oob = 1'b1;
            end
         end
      end
   end

   // Route at most one writer per bank; out-of-range writes are dropped
   always_comb begin
      bk_we   = '0;
      bk_wrow = '0;
      bk_wdat = '0;
      bk_rrow = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
         if (grant[l]) begin
            bk_rrow[bank_of(va_q[l])] = row_of(va_q[l]);
            if (req_we_q && in_range(va_q[l])) begin
               bk_we[bank_of(va_q[l])]   = 1'b1;
               bk_wrow[bank_of(va_q[l])] = row_of(va_q[l]);
               bk_wdat[bank_of(va_q[l])] = wd_q[l];
            end
         end
      end
      if (we && in_range(a)) begin
         bk_we[sc_bank]   = 1'b1;
         bk_wrow[sc_bank] = row_of(a);
         bk_wdat[sc_bank] = wd[7:0];
      end
   end

   for (genvar b = 0; b < LANES; b++) begin : g_bank
      logic [7:0] mem [ROWS];

      // Single write port per bank; reads below are pre-write taps
      always_ff @(posedge clk) begin
         if (bk_we[b]) mem[bk_wrow[b]] <= bk_wdat[b];
      end

      assign sc_rd[b]   = mem[row_of(a)];
      assign vga_rd[b]  = mem[row_of(avga)];
      assign lane_rd[b] = mem[bk_rrow[b]];
   end

   // Scalar and display read registers, updated every edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd    <= '0;
         rdvga <= '0;
      end else begin
         rd    <= in_range(a)    ? {24'b0, sc_rd[sc_bank]}   : '0;
         rdvga <= in_range(avga) ? {24'b0, vga_rd[vga_bank]} : '0;
      end
   end

   // Sticky out-of-range flag over all three ports
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         oob_err <= 1'b0;
      end else if (!in_range(a) || !in_range(avga) || lane_oob) begin
         oob_err <= 1'b1;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // FSM next state and handshake outputs
   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = (lane_en == '0) ? RESP : ISSUE;
         end
         ISSUE: begin
            if ((pending & ~grant) == '0) state_nxt = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request capture, pending bookkeeping and per-lane read capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_we_q <= 1'b0;
         va_q     <= '0;
         wd_q     <= '0;
         pending  <= '0;
         rdv      <= '0;
      end else begin
         if (state == IDLE && req_valid) begin
            req_we_q <= req_we;
            va_q     <= va;
            pending  <= lane_en;
            for (int unsigned l = 0; l < LANES; l++) begin
               wd_q[l] <= wdv[l][7:0];
            end
         end else if (state == ISSUE) begin
            pending <= pending & ~grant;
         end
         for (int unsigned l = 0; l < LANES; l++) begin
            if (grant[l] && !req_we_q) begin
               rdv[l] <= in_range(va_q[l]) ? {24'b0, lane_rd[bank_of(va_q[l])]} : '0;
            end
         end
      end
   end

`ifdef DMEM_VEC_CONFLICT_CNT_EN
   logic first_issue;

   // Count every ISSUE cycle beyond the first of a request, saturating
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first_issue     <= 1'b0;
         conflict_cycles <= '0;
      end else begin
         first_issue <= (state == IDLE);
         if (state == ISSUE && !first_issue && conflict_cycles != '1) begin
            conflict_cycles <= conflict_cycles + 32'd1;
         end
      end
   end
`else
   assign conflict_cycles = '0;
`endif

endmodule

// File: tb/tb_dmem_vec.sv
// tb_dmem_vec: scoreboard bench for dmem_vec (LANES=4, DEPTH=1024).
module tb_dmem_vec;

   localparam int DEPTH = 1024;
   localparam int LANES = 4;
   localparam int AW    = 32;
   localparam logic [AW-1:0] PARK = 5;

   typedef logic [LANES-1:0][31:0] vec_t;
   typedef logic [LANES-1:0][AW-1:0] adr_t;

   logic             clk, rst_n, we;
   logic [AW-1:0]    a, avga;
   logic [31:0]      wd, rd, rdvga, conflict_cycles;
   logic             req_valid, req_ready, req_we, rsp_valid, rsp_ready, oob_err;
   logic [LANES-1:0] lane_en;
   adr_t             va;
   vec_t             wdv, rdv;

   dmem_vec #(.DEPTH(DEPTH), .LANES(LANES), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .we(we), .a(a), .wd(wd), .rd(rd),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .lane_en(lane_en), .va(va), .wdv(wdv), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rdv(rdv), .avga(avga), .rdvga(rdvga),
      .oob_err(oob_err), .conflict_cycles(conflict_cycles)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   logic [7:0]  mm [DEPTH];
   vec_t        rdv_m;
   int unsigned conf_m;
   vec_t        exp_q [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic adr_t adr4(input int unsigned a0, a1, a2, a3);
      adr_t r;
      r[0] = AW'(a0); r[1] = AW'(a1); r[2] = AW'(a2); r[3] = AW'(a3);
      return r;
   endfunction

   function automatic vec_t dat4(input logic [31:0] d0, d1, d2, d3);
      vec_t r;
      r[0] = d0; r[1] = d1; r[2] = d2; r[3] = d3;
      return r;
   endfunction

   function automatic logic [31:0] mread(input logic [AW-1:0] ad);
      return (ad < AW'(DEPTH)) ? {24'b0, mm[int'(ad)]} : 32'd0;
   endfunction

   // Cycles needed to serve a request: the most lanes sharing one bank
   function automatic int issue_cycles(input logic [LANES-1:0] en, input adr_t ad);
      int cnt [LANES];
      int mx = 0;
      for (int b = 0; b < LANES; b++) cnt[b] = 0;
      for (int l = 0; l < LANES; l++) if (en[l]) cnt[int'(ad[l] % LANES)]++;
      for (int b = 0; b < LANES; b++) if (cnt[b] > mx) mx = cnt[b];
      return mx;
   endfunction

   task automatic sc_write(input logic [AW-1:0] ad, input logic [31:0] d);
      we = 1'b1; a = ad; wd = d;
      tick();
      we = 1'b0; a = PARK;
      if (ad < AW'(DEPTH)) mm[int'(ad)] = d[7:0];
   endtask

   task automatic sc_read(input string tag, input logic [AW-1:0] ad);
      a = ad;
      tick();
      check_eq(tag, 128'(rd), 128'(mread(ad)));
      a = PARK;
   endtask

   // One vector transaction; clash=1 writes address 0 from the scalar port
   // during the first ISSUE cycle so lane 0 (at address 0) must wait.
   task automatic vec_req(input string tag, input logic wr, input logic [LANES-1:0] en,
                          input adr_t ad, input vec_t d, input int hold, input logic clash);
      int   n;
      int   exp_n;
      vec_t exp;
      exp_n = issue_cycles(en, ad) + (clash ? 1 : 0);
      if (clash) mm[0] = 8'h5A;
      for (int l = 0; l < LANES; l++) begin
         if (en[l]) begin
            if (ad[l] < AW'(DEPTH)) begin
               if (wr) mm[int'(ad[l])] = d[l][7:0];
               else    rdv_m[l] = {24'b0, mm[int'(ad[l])]};
            end else if (!wr) begin
               rdv_m[l] = '0;
            end
         end
      end
      exp_q.push_back(rdv_m);
`ifdef DMEM_VEC_CONFLICT_CNT_EN
      if (exp_n > 1) conf_m += exp_n - 1;
`endif
      check_eq({tag, " ready"}, 128'(req_ready), 128'(1));
      req_valid = 1'b1; req_we = wr; lane_en = en; va = ad; wdv = d;
      tick();
      req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 64) begin
         if (clash && n == 0) begin we = 1'b1; a = '0; wd = 32'h0000005A; end
         tick();
         we = 1'b0; a = PARK;
         n++;
      end
      check_eq({tag, " latency"}, 128'(n), 128'(exp_n));
      exp = exp_q.pop_front();
      for (int i = 0; i < hold; i++) begin
         check_eq({tag, " hold valid"}, 128'(rsp_valid), 128'(1));
         check_eq({tag, " hold rdv"}, 128'(rdv), 128'(exp));
         tick();
      end
      check_eq({tag, " rdv"}, 128'(rdv), 128'(exp));
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check_eq({tag, " done"}, 128'({rsp_valid, req_ready}), 128'(2'b01));
      check_eq({tag, " conflicts"}, 128'(conflict_cycles), 128'(conf_m));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) mm[i] = 8'h00;
      rdv_m = '0; conf_m = 0;
      rst_n = 1'b0; we = 1'b0; a = PARK; wd = '0; avga = PARK;
      req_valid = 1'b0; req_we = 1'b0; lane_en = '0; va = '0; wdv = '0; rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset rd", 128'(rd), 128'(0));
      check_eq("reset rdvga", 128'(rdvga), 128'(0));
      check_eq("reset rdv", 128'(rdv), 128'(0));
      check_eq("reset flags", 128'({rsp_valid, req_ready, oob_err}), 128'(3'b010));
      check_eq("reset conflicts", 128'(conflict_cycles), 128'(0));
      rst_n = 1'b1;
      tick();

      // Scalar and display ports, including read-before-write
      sc_write(5, 32'h123400A5);
      tick();
      check_eq("scalar rd", 128'(rd), 128'(32'hA5));
      check_eq("vga rd", 128'(rdvga), 128'(32'hA5));
      we = 1'b1; a = 5; wd = 32'hB6;
      tick();
      check_eq("scalar rbw", 128'(rd), 128'(32'hA5));
      check_eq("vga rbw", 128'(rdvga), 128'(32'hA5));
      we = 1'b0; mm[5] = 8'hB6;
      tick();
      check_eq("scalar after write", 128'(rd), 128'(32'hB6));

      // Conflict-free write then read, partial mask, empty mask
      vec_req("vw free", 1'b1, 4'hF, adr4(0, 1, 2, 3),
              dat4(32'hDEAD0011, 32'hBEEF0022, 32'h00000033, 32'hFFFFFF44), 0, 1'b0);
      vec_req("vr free", 1'b0, 4'hF, adr4(0, 1, 2, 3), '0, 0, 1'b0);
      vec_req("vr partial", 1'b0, 4'b0101, adr4(5, 0, 2, 0), '0, 0, 1'b0);
      vec_req("vr empty", 1'b0, 4'h0, adr4(1, 2, 3, 0), '0, 0, 1'b0);

      // Full bank-0 conflict, write then read back
      vec_req("vw conflict", 1'b1, 4'hF, adr4(4, 8, 12, 16),
              dat4(32'h91, 32'h92, 32'h93, 32'h94), 0, 1'b0);
      vec_req("vr conflict", 1'b0, 4'hF, adr4(16, 12, 8, 4), '0, 0, 1'b0);

      // Same address in every lane: highest lane wins
      vec_req("vw same", 1'b1, 4'hF, adr4(7, 7, 7, 7), dat4(1, 2, 3, 4), 0, 1'b0);
      sc_read("same addr rd", 7);
      vec_req("vr same", 1'b0, 4'hF, adr4(7, 7, 7, 7), '0, 0, 1'b0);

      // Scalar write takes bank 0 for one cycle; response held 3 cycles
      vec_req("vw clash", 1'b1, 4'hF, adr4(0, 41, 42, 43),
              dat4(32'hC0, 32'hC1, 32'hC2, 32'hC3), 3, 1'b1);
      sc_read("clash rd0", 0);
      sc_read("clash rd41", 41);

      // Out-of-range vector write is dropped, read returns zero
      vec_req("vw oob", 1'b1, 4'b0100, adr4(0, 0, DEPTH + 2, 0), dat4(0, 0, 32'hEE, 0), 0, 1'b0);
      check_eq("oob after vw", 128'(oob_err), 128'(1));
      sc_read("oob alias rd2", 2);
      vec_req("vr oob", 1'b0, 4'hF, adr4(0, 1, DEPTH, 3), '0, 0, 1'b0);

      // Reset in the middle of a conflicting write
      sc_write(28, 32'hEE);
      req_valid = 1'b1; req_we = 1'b1; lane_en = 4'hF;
      va = adr4(20, 24, 28, 32); wdv = dat4(32'h61, 32'h62, 32'h63, 32'h64);
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      mm[20] = 8'h61; mm[24] = 8'h62;
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
      #1;
      rdv_m = '0; conf_m = 0;
      check_eq("abort flags", 128'({rsp_valid, req_ready, oob_err}), 128'(3'b010));
      check_eq("abort rdv", 128'(rdv), 128'(0));
      check_eq("abort conflicts", 128'(conflict_cycles), 128'(0));
      tick();
      tick();
      check_eq("abort idle", 128'({rsp_valid, req_ready}), 128'(2'b01));
      sc_read("abort rd20", 20);
      sc_read("abort rd24", 24);
      sc_read("abort rd28", 28);

      // Scalar and display out-of-range accesses
      sc_write(DEPTH + 3, 32'h77);
      check_eq("scalar oob rd", 128'(rd), 128'(0));
      check_eq("scalar oob flag", 128'(oob_err), 128'(1));
      sc_read("scalar oob alias rd3", 3);
      avga = DEPTH;
      tick();
      check_eq("vga oob rd", 128'(rdvga), 128'(0));
      avga = PARK;
      tick();
      check_eq("oob sticky", 128'(oob_err), 128'(1));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
